// File: rtl/mult8x8_datapath_pkg.sv
// Shared encodings for the 8x8 sequential multiplier datapath and its controller.
package mult8x8_datapath_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned ProdWidth = 2 * DataWidth;

  typedef enum logic [1:0] {
    SEL_LL = 2'b00,
    SEL_LH = 2'b01,
    SEL_HL = 2'b10,
    SEL_HH = 2'b11
  } input_sel_e;

  typedef enum logic [1:0] {
    SHIFT_0   = 2'b00,
    SHIFT_4   = 2'b01,
    SHIFT_8   = 2'b10,
    SHIFT_BAD = 2'b11
  } shift_sel_e;

  // Controller state codes; the datapath itself never decodes these.
  typedef enum logic [2:0] {
    CtlIdle,
    CtlLsb,
    CtlMid,
    CtlMsb,
    CtlDone,
    CtlErr
  } ctl_state_e;

  // The only shift that is legal alongside each nibble-pair select.
  function automatic shift_sel_e legal_shift(input logic [1:0] sel);
    case (sel)
      SEL_LL:  return SHIFT_0;
      SEL_LH:  return SHIFT_4;
      SEL_HL:  return SHIFT_4;
      default: return SHIFT_8;
    endcase
  endfunction

endpackage

// File: rtl/mult8x8_datapath_if.sv
// Command/status bundle between the multiplier controller/host and the datapath.
interface mult8x8_datapath_if;
  import mult8x8_datapath_pkg::*;

  logic                 start;
  logic [DataWidth-1:0] dataa;
  logic [DataWidth-1:0] datab;
  logic                 clk_ena;
  logic                 sclr_n;
  logic [1:0]           input_sel;
  logic [1:0]           shift_sel;
  logic                 done;
  logic [1:0]           count;
  logic [ProdWidth-1:0] product;
  logic [ProdWidth-1:0] result;
  logic                 result_valid;
  logic                 seq_err;

  modport master (
    output start, dataa, datab, clk_ena, sclr_n, input_sel, shift_sel, done,
    input  count, product, result, result_valid, seq_err
  );

  modport slave (
    input  start, dataa, datab, clk_ena, sclr_n, input_sel, shift_sel, done,
    output count, product, result, result_valid, seq_err
  );

endinterface

// File: rtl/mult8x8_datapath_mult4x4.sv
// Combinational unsigned 4x4 -> 8 multiplier forming one partial product.
module mult8x8_datapath_mult4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  always_comb begin
    p_o = {4'b0000, a_i} * {4'b0000, b_i};
  end

endmodule

// File: rtl/mult8x8_datapath.sv
// Datapath for the sequential 8x8 multiplier: nibble mux, 4x4 multiply, shift,
// accumulate, step counter, result capture and step-order checking.
module mult8x8_datapath
  import mult8x8_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_a,
  mult8x8_datapath_if.slave bus
);

  localparam int unsigned Nib = WIDTH / 2;

  logic [Nib-1:0]     op_a, op_b;
  logic [WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0] pp_ext, shifted;
  logic               step_bad, first_ok, set_err, clr_err;

  logic [1:0]         count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               final_q, final_d;

  always_comb begin
    op_a = bus.input_sel[1] ? bus.dataa[WIDTH-1:Nib] : bus.dataa[Nib-1:0];
    op_b = bus.input_sel[0] ? bus.datab[WIDTH-1:Nib] : bus.datab[Nib-1:0];
  end

  mult8x8_datapath_mult4x4 u_mult4x4 (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (pp)
  );

  always_comb begin
    pp_ext = {{WIDTH{1'b0}}, pp};
    case (bus.shift_sel)
      SHIFT_4: shifted = pp_ext << Nib;
      SHIFT_8: shifted = pp_ext << WIDTH;
      default: shifted = pp_ext;
    endcase
  end

  always_comb begin
    step_bad = bus.sclr_n ? (bus.input_sel != count_q) : (bus.input_sel != SEL_LL);
    step_bad = step_bad | (bus.shift_sel != legal_shift(bus.input_sel));
    first_ok = !bus.sclr_n && (bus.input_sel == SEL_LL) && (bus.shift_sel == SHIFT_0);
    // count has already wrapped to 0 when done arrives, so done is qualified by
    // whether the previous step was the fourth (taken at count 3).
    set_err  = (bus.clk_ena && !bus.start && step_bad) || (bus.done && !final_q);
    clr_err  = bus.clk_ena && first_ok;
  end

  always_comb begin
    product_d = product_q;
    count_d   = count_q;
    final_d   = final_q;
    result_d  = result_q;
    valid_d   = valid_q;
    err_d     = err_q;

    if (bus.clk_ena) begin
      product_d = bus.sclr_n ? product_q + shifted : shifted;
    end

    if (bus.start) begin
      count_d = 2'd0;
      final_d = 1'b0;
    end else if (bus.clk_ena) begin
      count_d = bus.sclr_n ? count_q + 2'd1 : 2'd1;
      final_d = bus.sclr_n && (count_q == 2'd3);
    end

    if (bus.clk_ena && !bus.sclr_n) begin
      valid_d = 1'b0;
    end
    if (bus.done && final_q) begin
      result_d = product_q;
      valid_d  = 1'b1;
    end

    if (set_err) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      count_q   <= '0;
      product_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      final_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      product_q <= product_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      final_q   <= final_d;
    end
  end

  assign bus.count        = count_q;
  assign bus.product      = product_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.seq_err      = err_q;

endmodule

// File: tb/tb_mult8x8_datapath.sv
// Self-checking bench: bench-side controller drives the datapath; expectations come
// from plain arithmetic on the operands.
module tb_mult8x8_datapath;
  import mult8x8_datapath_pkg::*;

  logic clk = 1'b0;
  logic reset_a = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mult8x8_datapath_if bus ();

  mult8x8_datapath #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of commands; returns 1 time unit after the active edge.
  task automatic drive(input logic st, input logic ena, input logic scl,
                       input logic [1:0] isel, input logic [1:0] ssel, input logic dn);
    bus.start     = st;
    bus.clk_ena   = ena;
    bus.sclr_n    = scl;
    bus.input_sel = isel;
    bus.shift_sel = ssel;
    bus.done      = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b0);
  endtask

  // Controller model: start, lsb, mid (twice, branching on count), msb, done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    ctl_state_e st;
    int guard;
    bus.dataa = a;
    bus.datab = b;
    drive(1'b1, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b0);
    st = CtlLsb;
    guard = 0;
    while (st != CtlIdle) begin
      guard++;
      if (guard > 10) begin
        chk("controller_budget", 32'(guard), 32'd6);
        st = CtlIdle;
      end else begin
        case (st)
          CtlLsb: begin
            drive(1'b0, 1'b1, 1'b0, SEL_LL, SHIFT_0, 1'b0);
            st = CtlMid;
          end
          CtlMid: begin
            if (bus.count == 2'd2) begin
              drive(1'b0, 1'b1, 1'b1, SEL_HL, SHIFT_4, 1'b0);
              st = CtlMsb;
            end else begin
              drive(1'b0, 1'b1, 1'b1, SEL_LH, SHIFT_4, 1'b0);
            end
          end
          CtlMsb: begin
            drive(1'b0, 1'b1, 1'b1, SEL_HH, SHIFT_8, 1'b0);
            st = CtlDone;
          end
          default: begin
            drive(1'b0, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b1);
            st = CtlIdle;
          end
        endcase
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a, b;
    logic [15:0] p, r;

    bus.dataa = 8'h00;
    bus.datab = 8'h00;
    bus.start = 1'b0;
    bus.clk_ena = 1'b0;
    bus.sclr_n = 1'b1;
    bus.input_sel = 2'b00;
    bus.shift_sel = 2'b00;
    bus.done = 1'b0;

    #12;
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_product", 32'(bus.product), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);
    chk("reset_valid", 32'(bus.result_valid), 32'd0);
    chk("reset_seq_err", 32'(bus.seq_err), 32'd0);
    reset_a = 1'b1;
    idle();

    // Step-by-step walk for a=0xA5, b=0x3C.
    bus.dataa = 8'hA5;
    bus.datab = 8'h3C;
    drive(1'b1, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, SEL_LL, SHIFT_0, 1'b0);
    chk("a5_step1_product", 32'(bus.product), 32'h003C);
    chk("a5_step1_count", 32'(bus.count), 32'd1);
    drive(1'b0, 1'b1, 1'b1, SEL_LH, SHIFT_4, 1'b0);
    chk("a5_step2_product", 32'(bus.product), 32'h012C);
    chk("a5_step2_count", 32'(bus.count), 32'd2);
    drive(1'b0, 1'b1, 1'b1, SEL_HL, SHIFT_4, 1'b0);
    chk("a5_step3_product", 32'(bus.product), 32'h08AC);
    chk("a5_step3_count", 32'(bus.count), 32'd3);
    drive(1'b0, 1'b1, 1'b1, SEL_HH, SHIFT_8, 1'b0);
    chk("a5_step4_product", 32'(bus.product), 32'h26AC);
    chk("a5_step4_count", 32'(bus.count), 32'd0);
    chk("a5_no_early_valid", 32'(bus.result_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b1);
    chk("a5_result", 32'(bus.result), 32'h26AC);
    chk("a5_valid", 32'(bus.result_valid), 32'd1);
    chk("a5_seq_err", 32'(bus.seq_err), 32'd0);
    idle();

    // Table of controller-coupled operations.
    vecs[0] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01};
    vecs[1] = '{a: 8'h00, b: 8'h80, exp: 16'h0000};
    vecs[2] = '{a: 8'h80, b: 8'h80, exp: 16'h4000};
    vecs[3] = '{a: 8'h01, b: 8'h01, exp: 16'h0001};
    vecs[4] = '{a: 8'h0F, b: 8'hF0, exp: 16'h0E10};
    vecs[5] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8};
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_result", i), 32'(bus.result), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_valid", i), 32'(bus.result_valid), 32'd1);
      chk($sformatf("vec%0d_seq_err", i), 32'(bus.seq_err), 32'd0);
      idle();
    end

    // Randomised operations against a*b.
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_op(a, b);
      chk($sformatf("rand%0d_result_%0h_x_%0h", i, a, b), 32'(bus.result), 32'(a) * 32'(b));
      chk($sformatf("rand%0d_valid", i), 32'(bus.result_valid), 32'd1);
    end
    idle();

    // Out-of-order step: input_sel=10 at count=1.
    bus.dataa = 8'h37;
    bus.datab = 8'h9B;
    drive(1'b1, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, SEL_LL, SHIFT_0, 1'b0);
    chk("order_pre_err", 32'(bus.seq_err), 32'd0);
    drive(1'b0, 1'b1, 1'b1, SEL_HL, SHIFT_4, 1'b0);
    chk("order_err_set", 32'(bus.seq_err), 32'd1);
    drive(1'b0, 1'b1, 1'b1, SEL_HL, SHIFT_4, 1'b0);
    drive(1'b0, 1'b1, 1'b1, SEL_HH, SHIFT_8, 1'b0);
    drive(1'b0, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b1);
    chk("order_err_sticky", 32'(bus.seq_err), 32'd1);
    drive(1'b0, 1'b1, 1'b0, SEL_LL, SHIFT_0, 1'b0);
    chk("order_err_cleared", 32'(bus.seq_err), 32'd0);
    chk("order_valid_cleared", 32'(bus.result_valid), 32'd0);
    idle();

    // Asynchronous reset mid-operation at count=2.
    bus.dataa = 8'hC3;
    bus.datab = 8'h5A;
    drive(1'b1, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, SEL_LL, SHIFT_0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, SEL_LH, SHIFT_4, 1'b0);
    chk("arst_pre_count", 32'(bus.count), 32'd2);
    #2;
    reset_a = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_product", 32'(bus.product), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_valid", 32'(bus.result_valid), 32'd0);
    chk("arst_seq_err", 32'(bus.seq_err), 32'd0);
    reset_a = 1'b1;
    idle();

    // start coincident with an accumulate step at count=2, then a shift_sel=11 step.
    a = 8'h6D;
    b = 8'hE2;
    bus.dataa = a;
    bus.datab = b;
    drive(1'b1, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, SEL_LL, SHIFT_0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, SEL_LH, SHIFT_4, 1'b0);
    p = 16'(a[3:0] * b[3:0]) + (16'(a[3:0] * b[7:4]) << 4);
    chk("coinc_pre_product", 32'(bus.product), 32'(p));
    drive(1'b1, 1'b1, 1'b1, SEL_HL, SHIFT_4, 1'b0);
    p = p + (16'(a[7:4] * b[3:0]) << 4);
    chk("coinc_count", 32'(bus.count), 32'd0);
    chk("coinc_product", 32'(bus.product), 32'(p));
    chk("coinc_seq_err", 32'(bus.seq_err), 32'd0);
    drive(1'b0, 1'b1, 1'b1, SEL_LL, SHIFT_BAD, 1'b0);
    p = p + 16'(a[3:0] * b[3:0]);
    chk("shift11_seq_err", 32'(bus.seq_err), 32'd1);
    chk("shift11_product", 32'(bus.product), 32'(p));
    idle();

    // done at count=1 leaves result and result_valid alone and flags an error.
    a = 8'hB7;
    b = 8'h29;
    run_op(a, b);
    r = 16'(a) * 16'(b);
    chk("early_done_ref_result", 32'(bus.result), 32'(r));
    chk("early_done_ref_err", 32'(bus.seq_err), 32'd0);
    bus.dataa = 8'h44;
    bus.datab = 8'h55;
    drive(1'b1, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, SEL_LL, SHIFT_0, 1'b0);
    chk("early_done_count", 32'(bus.count), 32'd1);
    drive(1'b0, 1'b0, 1'b1, SEL_LL, SHIFT_0, 1'b1);
    chk("early_done_result", 32'(bus.result), 32'(r));
    chk("early_done_valid", 32'(bus.result_valid), 32'd0);
    chk("early_done_seq_err", 32'(bus.seq_err), 32'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
